// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; drives the execute-stage stall.
// Operands are latched at launch and the result lands on HI/LO when the run counter expires.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        Start,
   input  logic [2:0]  MD_Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Cancel,
   output logic        Busy,
   output logic        MD_Stall,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    op_q, op_d;
   logic [31:0]   a_q, a_d, b_q, b_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;

   logic          accept;
   logic [63:0]   prod_s, prod_u;
   logic [31:0]   a_mag, b_mag, s_den, u_den;
   logic [31:0]   sq_mag, sr_mag, s_quo, s_rem, u_quo, u_rem;

   assign accept   = Start & ~Cancel;
   assign Busy     = (state_q == RUN);
   assign MD_Stall = Busy | (accept & ~MD_Op[2]);
   assign HI       = hi_q;
   assign LO       = lo_q;

   // Low 64 bits of the sign-extended product equal the signed product.
   assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};

   // Signed divide on magnitudes so 0x80000000 / -1 needs no special case.
   assign a_mag  = a_q[31] ? -a_q : a_q;
   assign b_mag  = b_q[31] ? -b_q : b_q;
   assign s_den  = (b_mag == 32'd0) ? 32'd1 : b_mag;
   assign u_den  = (b_q == 32'd0) ? 32'd1 : b_q;
   assign sq_mag = a_mag / s_den;
   assign sr_mag = a_mag % s_den;
   assign s_quo  = (a_q[31] ^ b_q[31]) ? -sq_mag : sq_mag;
   assign s_rem  = a_q[31] ? -sr_mag : sr_mag;
   assign u_quo  = a_q / u_den;
   assign u_rem  = a_q % u_den;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (MD_Op)
                  3'b000, 3'b001, 3'b010, 3'b011: begin
                     state_d = RUN;
                     op_d    = MD_Op[1:0];
                     a_d     = A;
                     b_d     = B;
                     cnt_d   = MD_Op[1] ? DIV_LOAD : MULT_LOAD;
                  end
                  3'b100:  hi_d = A;
                  3'b101:  lo_d = A;
                  default: ;
               endcase
            end
         end
         RUN: begin
            // Start and Cancel are deliberately ignored while running.
            if (cnt_q == '0) begin
               state_d = IDLE;
               case (op_q)
                  2'b00: {hi_d, lo_d} = prod_s;
                  2'b01: {hi_d, lo_d} = prod_u;
                  2'b10: if (b_q != 32'd0) begin
                     hi_d = s_rem;
                     lo_d = s_quo;
                  end
                  default: if (b_q != 32'd0) begin
                     hi_d = u_rem;
                     lo_d = u_quo;
                  end
               endcase
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit in the execute stage, owning the HI/LO registers. It is the source side of the stall handshake. It raises `MD_Stall` while an operation is in flight or being launched, and the pipeline stall controller turns that into a frozen PC, a frozen decode register and a flushed execute register. It also honours the interrupt/exception cancel, so that a flushed instruction never starts an operation.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: cycles Busy stays high for mult/multu (at least 1).
- `DIV_CYCLES`, default 10: cycles Busy stays high for div/divu (at least 1).

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  E-stage instruction is an MD operation; valid for one cycle.
- `MD_Op`  in  3  operation code:
  - 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo.
  - 110 and 111 are no-ops.
- `A`  in  32  rs operand.
- `B`  in  32  rt operand.
- `Cancel`  in  1  interrupt/exception flush of the E-stage instruction this cycle.
- `Busy`  out  1  registered; an operation is in flight.
- `MD_Stall`  out  1  combinational: `Busy | (Start & ~Cancel & MD_Op[2]==0)`.
- `HI`  out  32  registered HI.
- `LO`  out  32  registered LO.

## Operation
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1; down-counter `cnt` (width ≥ clog2 of the larger cycle parameter), latched op, latched A and B.
- IDLE → RUN on a clock edge with `Start=1`, `Cancel=0` and `MD_Op` in 000..011:
  - latch `A`, `B` and `MD_Op`;
  - load `cnt` with N-1, where N is `MULT_CYCLES` or `DIV_CYCLES`.
- In RUN:
  - `cnt` decrements each edge;
  - on the edge where `cnt==0`, HI/LO are written and the state returns to IDLE.
- mthi/mtlo (`Start=1`, `Cancel=0`, IDLE): on that edge, `HI<=A` or `LO<=A`; the state stays IDLE and Busy never rises.
- Arithmetic, computed on the latched operands:
  - mult: {HI,LO} = signed A × signed B, full 64-bit product.
  - multu: {HI,LO} = unsigned A × unsigned B, full 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: LO = unsigned quotient; HI = unsigned remainder.
  - div/divu with B=0: HI and LO keep their old values; Busy still runs the full `DIV_CYCLES`.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Boundary rules:
  - `Start` while RUN: ignored, including mthi/mtlo. The upstream stall makes this illegal, but the unit must not corrupt state.
  - `Cancel=1` with `Start=1`: no launch and no HI/LO write; `MD_Stall` follows `Busy` only.
  - `Cancel` during RUN: no effect. An in-flight operation belongs to an already-committed instruction and completes.
  - Codes 110/111 with `Start`: no state change.
  - `reset_n` low at any time, including mid-RUN: immediately forces IDLE, Busy=0, `cnt=0`, HI=0, LO=0. The operation is abandoned.

## Timing
- Reset values: `Busy=0`, `HI=0`, `LO=0`; `MD_Stall` follows its inputs.
- mult/div launch sampled at edge t:
  - `Busy`=1 from after edge t to edge t+N, i.e. exactly N cycles high;
  - HI/LO take the result at edge t+N, the same edge Busy falls.
- `MD_Stall` is high from the launch cycle (combinational) through the last Busy cycle: N+1 cycles in total.
- Back-to-back operations: a new `Start` accepted on the edge after Busy falls begins its own N-cycle run; no extra gap cycle.
- mthi/mtlo: value visible on HI/LO one cycle after `Start`; `MD_Stall` is not asserted.
- HI/LO reads during RUN return the old values. Stall logic upstream prevents mfhi/mflo from reaching E.

## Test plan
- Reset, then mult with A=0xFFFFFFFE (-2), B=3 → Busy high exactly 5 cycles; at fall HI=0xFFFFFFFF, LO=0xFFFFFFFA; `MD_Stall` high 6 cycles.
- multu with A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- div with A=-7 (0xFFFFFFF9), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu 7/0 → Busy runs 10 cycles, HI/LO unchanged.
- mthi with A=0x12345678 → HI=0x12345678 next cycle, Busy stays 0. Start mult with `Cancel=1` in the same cycle → no Busy, no HI/LO change, `MD_Stall`=0.
- Start div; assert `Start`=mtlo (A=0xDEAD) at cycle 3 and `Cancel` at cycle 5 → both ignored; div result written at cycle 10; LO≠0xDEAD.
- Start div; drop `reset_n` at cycle 4 → Busy=0 and HI=LO=0 immediately; after release, no late write occurs over the following 20 cycles.
